// File: rtl/periph_pkg.sv
// Shared types and constants for the peripheral receive path.
// Holds the FIFO occupancy state encoding and the status counter width.
package periph_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

  localparam int CNT_W = 16;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/periph_fifo.sv
// Word storage and read/write pointers for periph_receiver.
// Keeps the head word in its own register so the output never sees the input directly.
module periph_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              empty,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              last_slot,
  output logic              last_word
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_inc;
  logic [PTR_W-1:0]  rd_inc;

  // DEPTH is a power of two, so the natural pointer wrap is the modulo.
  assign wr_inc    = wr_ptr + 1'b1;
  assign rd_inc    = rd_ptr + 1'b1;
  assign last_slot = (wr_inc == rd_ptr);
  assign last_word = (rd_inc == wr_ptr);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_inc;
      end
      if (pop) begin
        rd_ptr <= rd_inc;
      end
    end
  end

  // The head register tracks what will sit at rd_ptr after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (pop) begin
      if (!last_word) begin
        head <= mem[rd_inc];
      end else if (push) begin
        head <= din;
      end
    end else if (push && empty) begin
      head <= din;
    end
  end

endmodule

// File: rtl/periph_receiver.sv
// Receives CPU words into a small FIFO, tracks occupancy, drops and status counters.
// Optional running XOR checksum enabled by defining PERIPH_RECEIVER_CHECKSUM_EN.
module periph_receiver
  import periph_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_periph,
  input  logic              rst_periph,
  input  logic              inSEND_periph,
  input  logic [DATA_W-1:0] inDATA_periph,
  input  logic              inREADY_periph,
  input  logic              inCLR_periph,
  output logic              outACK_periph,
  output logic              outVALID_periph,
  output logic [DATA_W-1:0] outDATA_periph,
  output logic              outOVF_periph,
  output logic [CNT_W-1:0]  outDROP_periph,
  output logic [CNT_W-1:0]  outRXCNT_periph,
  output logic [DATA_W-1:0] outCHK_periph
);

  occ_state_t state;
  occ_state_t state_nxt;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop_evt;
  logic       last_slot;
  logic       last_word;

  assign empty           = (state == EMPTY);
  assign full            = (state == FULL);
  assign outVALID_periph = !empty;
  assign pop             = outVALID_periph && inREADY_periph;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push            = inSEND_periph && (!full || pop);
  assign drop_evt        = inSEND_periph && full && !pop;

  periph_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk_periph),
    .rst_n    (rst_periph),
    .push     (push),
    .pop      (pop),
    .empty    (empty),
    .din      (inDATA_periph),
    .head     (outDATA_periph),
    .last_slot(last_slot),
    .last_word(last_word)
  );

  always_ff @(posedge clk_periph or negedge rst_periph) begin
    if (!rst_periph) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = PARTIAL;
        end
      end
      PARTIAL: begin
        if (push && !pop && last_slot) begin
          state_nxt = FULL;
        end else if (pop && !push && last_word) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop && !push) begin
          state_nxt = PARTIAL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_periph or negedge rst_periph) begin
    if (!rst_periph) begin
      outACK_periph   <= 1'b0;
      outRXCNT_periph <= '0;
    end else begin
      outACK_periph <= push;
      if (push) begin
        outRXCNT_periph <= outRXCNT_periph + 1'b1;
      end
    end
  end

  // Clear takes priority over a drop landing on the same edge.
  always_ff @(posedge clk_periph or negedge rst_periph) begin
    if (!rst_periph) begin
      outOVF_periph  <= 1'b0;
      outDROP_periph <= '0;
    end else if (inCLR_periph) begin
      outOVF_periph  <= 1'b0;
      outDROP_periph <= '0;
    end else if (drop_evt) begin
      outOVF_periph  <= 1'b1;
      outDROP_periph <= sat_inc(outDROP_periph);
    end
  end

`ifdef PERIPH_RECEIVER_CHECKSUM_EN
  always_ff @(posedge clk_periph or negedge rst_periph) begin
    if (!rst_periph) begin
      outCHK_periph <= '0;
    end else if (push) begin
      outCHK_periph <= outCHK_periph ^ inDATA_periph;
    end
  end
`else
  assign outCHK_periph = '0;
`endif

endmodule

// File: tb/tb_periph_receiver.sv
// Directed, table-driven bench for periph_receiver (DEPTH 4, DATA_W 32).
// Honours PERIPH_RECEIVER_CHECKSUM_EN for the expected checksum value.
module tb_periph_receiver;

  logic        clk_periph;
  logic        rst_periph;
  logic        send;
  logic [31:0] data;
  logic        ready;
  logic        clr;
  logic        ack;
  logic        valid;
  logic [31:0] head;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic [15:0] rx_cnt;
  logic [31:0] chk;

  int errors = 0;
  int checks = 0;
  logic [31:0] chk_model;

  typedef struct {
    logic        send;
    logic [31:0] data;
    logic        ready;
    logic        clr;
    logic        exp_ack;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic [15:0] exp_drop;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs [19];

  periph_receiver #(
    .DEPTH (4),
    .DATA_W(32)
  ) dut (
    .clk_periph     (clk_periph),
    .rst_periph     (rst_periph),
    .inSEND_periph  (send),
    .inDATA_periph  (data),
    .inREADY_periph (ready),
    .inCLR_periph   (clr),
    .outACK_periph  (ack),
    .outVALID_periph(valid),
    .outDATA_periph (head),
    .outOVF_periph  (ovf),
    .outDROP_periph (drop_cnt),
    .outRXCNT_periph(rx_cnt),
    .outCHK_periph  (chk)
  );

  initial clk_periph = 1'b0;
  always #5 clk_periph = ~clk_periph;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] expChk(input logic [31:0] model);
`ifdef PERIPH_RECEIVER_CHECKSUM_EN
    return model;
`else
    return 32'h0 & model;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic applyStimulus(input logic s, input logic [31:0] d, input logic r, input logic c);
    send  = s;
    data  = d;
    ready = r;
    clr   = c;
    @(posedge clk_periph);
    #1;
  endtask

  task automatic doReset();
    rst_periph = 1'b0;
    send = 1'b0; data = '0; ready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk_periph);
    #2;
    rst_periph = 1'b1;
    chk_model = '0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0, 16'd1};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0, 16'd1};
    vecs[2]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0, 16'd2};
    vecs[3]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0, 16'd3};
    vecs[4]  = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0, 16'd4};
    vecs[5]  = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 16'd1, 16'd4};
    vecs[6]  = '{1'b1, 32'h55555555, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b1, 16'd1, 16'd5};
    vecs[7]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 16'd0, 16'd5};
    vecs[8]  = '{1'b1, 32'h66666666, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 16'd0, 16'd5};
    vecs[9]  = '{1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 16'd1, 16'd5};
    vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 16'd1, 16'd5};
    vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1, 16'd1, 16'd5};
    vecs[12] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b1, 16'd1, 16'd5};
    vecs[13] = '{1'b1, 32'h88888888, 1'b1, 1'b0, 1'b1, 1'b1, 32'h88888888, 1'b1, 16'd1, 16'd6};
    vecs[14] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 16'd1, 16'd6};
    vecs[15] = '{1'b1, 32'h0000000F, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000000F, 1'b1, 16'd1, 16'd7};
    vecs[16] = '{1'b1, 32'h000000F0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000000F, 1'b1, 16'd1, 16'd8};
    vecs[17] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h000000F0, 1'b1, 16'd1, 16'd8};
    vecs[18] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 16'd1, 16'd8};

    doReset();
    checkOutput("reset ack",   {31'b0, ack},   32'h0);
    checkOutput("reset valid", {31'b0, valid}, 32'h0);
    checkOutput("reset data",  head,           32'h0);
    checkOutput("reset ovf",   {31'b0, ovf},   32'h0);
    checkOutput("reset drop",  {16'b0, drop_cnt}, 32'h0);
    checkOutput("reset rxcnt", {16'b0, rx_cnt},   32'h0);
    checkOutput("reset chk",   chk,            32'h0);

    @(negedge clk_periph);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].send, vecs[i].data, vecs[i].ready, vecs[i].clr);
      if (vecs[i].exp_ack) chk_model = chk_model ^ vecs[i].data;
      checkOutput($sformatf("v%0d ack", i),   {31'b0, ack},   {31'b0, vecs[i].exp_ack});
      checkOutput($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) checkOutput($sformatf("v%0d data", i), head, vecs[i].exp_data);
      checkOutput($sformatf("v%0d ovf", i),   {31'b0, ovf},   {31'b0, vecs[i].exp_ovf});
      checkOutput($sformatf("v%0d drop", i),  {16'b0, drop_cnt}, {16'b0, vecs[i].exp_drop});
      checkOutput($sformatf("v%0d rxcnt", i), {16'b0, rx_cnt},   {16'b0, vecs[i].exp_rx});
      checkOutput($sformatf("v%0d chk", i),   chk, expChk(chk_model));
    end

    // Checksum of two complementary nibble words from a clean start.
    doReset();
    @(negedge clk_periph);
    applyStimulus(1'b1, 32'h0000000F, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h000000F0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h00000000, 1'b0, 1'b0);
    checkOutput("chk pair", chk, expChk(32'h000000FF));
    checkOutput("chk pair rxcnt", {16'b0, rx_cnt}, 32'd2);
    checkOutput("chk pair head", head, 32'h0000000F);

    // Reset asserted mid-cycle with two words queued must clear at once.
    doReset();
    @(negedge clk_periph);
    applyStimulus(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
    checkOutput("pre-rst rxcnt", {16'b0, rx_cnt}, 32'd2);
    checkOutput("pre-rst ack",   {31'b0, ack},    32'h1);
    #3;
    rst_periph = 1'b0;
    #1;
    checkOutput("mid-rst valid", {31'b0, valid},  32'h0);
    checkOutput("mid-rst ack",   {31'b0, ack},    32'h0);
    checkOutput("mid-rst rxcnt", {16'b0, rx_cnt}, 32'h0);
    checkOutput("mid-rst chk",   chk,             32'h0);
    checkOutput("mid-rst data",  head,            32'h0);
    send = 1'b1;
    data = 32'hCCCC0000;
    @(posedge clk_periph);
    #1;
    checkOutput("in-rst send ignored", {31'b0, valid}, 32'h0);
    send = 1'b0;
    #2;
    rst_periph = 1'b1;
    @(negedge clk_periph);
    applyStimulus(1'b1, 32'hBBBB0001, 1'b0, 1'b0);
    checkOutput("post-rst ack",   {31'b0, ack},    32'h1);
    checkOutput("post-rst valid", {31'b0, valid},  32'h1);
    checkOutput("post-rst data",  head,            32'hBBBB0001);
    checkOutput("post-rst rxcnt", {16'b0, rx_cnt}, 32'd1);
    applyStimulus(1'b0, 32'h00000000, 1'b1, 1'b0);
    checkOutput("post-rst drain", {31'b0, valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/periph_receiver.md
PERIPH_RECEIVER -- requirements
Module: periph_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in words (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk_periph  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_periph  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port inSEND_periph  input  1  upstream CPU send strobe; word valid when high.
REQ-006 SHALL have port inDATA_periph  input  DATA_W  upstream CPU data word.
REQ-007 SHALL have port inREADY_periph  input  1  downstream consumer accepts head word.
REQ-008 SHALL have port inCLR_periph  input  1  synchronous clear of error status.
REQ-009 SHALL have port outACK_periph  output  1  one-cycle pulse, word accepted.
REQ-010 SHALL have port outVALID_periph  output  1  FIFO head word valid.
REQ-011 SHALL have port outDATA_periph  output  DATA_W  FIFO head word.
REQ-012 SHALL have port outOVF_periph  output  1  sticky overflow flag.
REQ-013 SHALL have port outDROP_periph  output  16  count of dropped words.
REQ-014 SHALL have port outRXCNT_periph  output  16  count of accepted words.
REQ-015 SHALL have port outCHK_periph  output  DATA_W  running XOR checksum of accepted words.

Function
REQ-016 SHALL sample inSEND_periph/inDATA_periph each rising edge; push = inSEND_periph high and (not full, or pop in same cycle).
REQ-017 SHALL define pop = outVALID_periph and inREADY_periph; head advances on that edge.
REQ-018 SHALL drive outVALID_periph high exactly when FIFO not empty; outDATA_periph = head word, registered, no combinational bypass.
REQ-019 SHALL give push-to-valid latency of 1 cycle: word sampled at edge N visible at outDATA_periph after edge N when FIFO was empty.
REQ-020 SHALL pulse outACK_periph high for the one cycle following each accepting edge; low otherwise.
REQ-021 SHALL, on inSEND_periph high while full and no pop, drop the word, set outOVF_periph, increment outDROP_periph saturating at 65535, leave outACK_periph low.
REQ-022 SHALL, on full with simultaneous push and pop, accept the word; occupancy stays DEPTH; no overflow.
REQ-023 SHALL, on empty with push and inREADY_periph high, not pop (VALID low); occupancy becomes 1.
REQ-024 SHALL increment outRXCNT_periph by 1 per accepted word, wrapping 65535 -> 0.
REQ-025 SHALL run occupancy FSM with states EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push; PARTIAL->FULL when push-only reaches DEPTH; PARTIAL->EMPTY when pop-only reaches 0; FULL->PARTIAL on pop-only; push+pop holds state.
REQ-026 SHALL, on inCLR_periph high, clear outOVF_periph and outDROP_periph next edge; a same-cycle drop is dropped but leaves flag/counter cleared (clear wins).
REQ-027 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-028 SHALL, while rst_periph low, immediately force: FSM EMPTY, pointers 0, outVALID_periph 0, outACK_periph 0, outOVF_periph 0, outDROP_periph 0, outRXCNT_periph 0, outCHK_periph 0, outDATA_periph 0.
REQ-029 SHALL discard FIFO contents on reset mid-operation; first push after release behaves as from empty.
REQ-030 SHALL ignore inSEND_periph while rst_periph is low.

Configuration
REQ-031 SHALL use macro PERIPH_RECEIVER_CHECKSUM_EN.
REQ-032 SHALL, with macro defined, update outCHK_periph <= outCHK_periph XOR word on every accepted word.
REQ-033 SHALL, without macro, keep outCHK_periph constant 0 and include no checksum register; port remains.

Structure
REQ-034 SHALL place occupancy state typedef (EMPTY, PARTIAL, FULL) and counter width constant 16 in shared package periph_pkg.
REQ-035 SHALL implement storage/pointers as sub-module periph_fifo; FSM, counters, ACK, checksum in top.

Verification
REQ-036 SHALL cover: reset, one SEND with data 0xDEADBEEF, READY low -> ACK pulse 1 cycle, VALID high with DATA 0xDEADBEEF, RXCNT 1.
REQ-037 SHALL cover: READY low, 5 SENDs (DEPTH 4) -> 4 ACKs, OVF 1, DROP 1, VALID stays high, head is first word.
REQ-038 SHALL cover: FIFO full, SEND and READY same cycle -> ACK, no OVF, occupancy 4, head advances.
REQ-039 SHALL cover: OVF set, CLR pulse -> OVF 0, DROP 0 next cycle; RXCNT unchanged.
REQ-040 SHALL cover: words 0x0000000F then 0x000000F0 with macro -> CHK 0x000000FF; without macro -> CHK 0.
REQ-041 SHALL cover: 2 words queued, rst_periph low mid-cycle -> VALID, counters, CHK 0 immediately, before next edge.
